i2s_mic_rx: RTL and testbench

//  I2S (Philips format) master receiver for a 24-bit MEMS microphone. Generates SCK/WS,

---
 rtl/i2s_mic_rx_if.sv | 33 +++
 rtl/i2s_mic_rx.sv | 106 ++++++++++
 tb/tb_i2s_mic_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_mic_rx_if.sv
// Bundles the I2S pins and the sample-delivery strobe between the microphone receiver and its users.
// The receiver drives through the master modport; the bench or the downstream tracker uses the slave modport.
interface i2s_mic_rx_if #(
  parameter int SAMPLE_BITS = 24
) ();
  logic                   en;
  logic                   i2s_sd;
  logic                   i2s_sck;
  logic                   i2s_ws;
  logic [SAMPLE_BITS-1:0] mic_data;
  logic                   mic_valid;
  logic                   finish_left_or_right;

  modport master (
    input  en,
    input  i2s_sd,
    output i2s_sck,
    output i2s_ws,
    output mic_data,
    output mic_valid,
    output finish_left_or_right
  );

  modport slave (
    output en,
    output i2s_sd,
    input  i2s_sck,
    input  i2s_ws,
    input  mic_data,
    input  mic_valid,
    input  finish_left_or_right
  );
endinterface

// File: rtl/i2s_mic_rx.sv
// Philips-format I2S master receiver: generates SCK/WS and deserialises signed samples from a MEMS mic.
// A sample is presented one clk after the SCK rise that carries its last bit; there is no backpressure.
module i2s_mic_rx #(
  parameter int CLK_DIV        = 4,
  parameter int SAMPLE_BITS    = 24,
  parameter int SLOT_BITS      = 32,
  parameter int STARTUP_FRAMES = 4
) (
  input logic         clk,
  input logic         rst_n,
  i2s_mic_rx_if.master bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(SLOT_BITS);
  localparam int FW = (STARTUP_FRAMES < 1) ? 1 : $clog2(STARTUP_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

  state_e                 state_q;
  logic [DW-1:0]          div_cnt_q;
  logic                   sck_q;
  logic                   ws_q;
  logic [PW-1:0]          pos_q;
  logic [FW-1:0]          frame_q;
  logic [SAMPLE_BITS-1:0] shift_q;
  logic                   done_q;
  logic [SAMPLE_BITS-1:0] mic_data_q;
  logic                   mic_valid_q;
  logic                   lr_q;

  logic div_wrap, rise_tick, fall_tick, pos_last, frame_end, capture, word_end;
  logic [SAMPLE_BITS-1:0] shift_d;

  assign div_wrap  = (div_cnt_q == DW'(CLK_DIV - 1));
  assign rise_tick = div_wrap && !sck_q;
  assign fall_tick = div_wrap && sck_q;
  assign pos_last  = (pos_q == PW'(SLOT_BITS - 1));
  assign frame_end = fall_tick && pos_last && ws_q;
  // Slot position 0 is the one-SCK I2S delay; payload occupies positions 1..SAMPLE_BITS.
  assign capture   = rise_tick && (pos_q != '0) && (pos_q <= PW'(SAMPLE_BITS));
  assign word_end  = rise_tick && (pos_q == PW'(SAMPLE_BITS));
  assign shift_d   = {shift_q[SAMPLE_BITS-2:0], bus.i2s_sd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      pos_q       <= '0;
      frame_q     <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      mic_data_q  <= '0;
      mic_valid_q <= 1'b0;
      lr_q        <= 1'b0;
    end else begin
      mic_valid_q <= 1'b0;
      if (!bus.en) begin
        state_q   <= IDLE;
        div_cnt_q <= '0;
        sck_q     <= 1'b0;
        ws_q      <= 1'b0;
        pos_q     <= '0;
        frame_q   <= '0;
        shift_q   <= '0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= (STARTUP_FRAMES == 0) ? RUN : WARMUP;
            // The enabling clk already counts as the first divider step.
            div_cnt_q <= DW'(1);
          end
          default: begin
            div_cnt_q <= div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap) sck_q <= !sck_q;
            if (fall_tick) begin
              pos_q <= pos_last ? '0 : pos_q + 1'b1;
              if (pos_last) ws_q <= !ws_q;
            end
            if (capture) shift_q <= shift_d;
            done_q <= word_end;
            if (done_q && (state_q == RUN)) begin
              mic_data_q  <= shift_q;
              lr_q        <= ws_q;
              mic_valid_q <= 1'b1;
            end
            if ((state_q == WARMUP) && frame_end) begin
              if (frame_q == FW'(STARTUP_FRAMES - 1)) state_q <= RUN;
              else frame_q <= frame_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.i2s_sck              = sck_q;
  assign bus.i2s_ws               = ws_q;
  assign bus.mic_data             = mic_data_q;
  assign bus.mic_valid            = mic_valid_q;
  assign bus.finish_left_or_right = lr_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a mic BFM feeds two receivers (no warm-up and two warm-up frames), a timing model
// predicts every output each clk, and directed checks pin the model to hand-computed cycle counts and samples.
module tb_i2s_mic_rx;
  localparam int CD = 2;
  localparam int SB = 24;
  localparam int SL = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic sd    = 1'b0;

  logic [SB-1:0] word_l = '0;
  logic [SB-1:0] word_r = '0;

  int n_chk    = 0;
  int n_fail   = 0;
  int since_en = 0;
  int bfm_bit  = 0;
  logic bfm_prev = 1'b0;

  always #5 clk = ~clk;

  i2s_mic_rx_if #(.SAMPLE_BITS(SB)) if0 ();
  i2s_mic_rx_if #(.SAMPLE_BITS(SB)) if2 ();

  assign if0.en     = en;
  assign if0.i2s_sd = sd;
  assign if2.en     = en;
  assign if2.i2s_sd = sd;

  i2s_mic_rx #(.CLK_DIV(CD), .SAMPLE_BITS(SB), .SLOT_BITS(SL), .STARTUP_FRAMES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master));
  i2s_mic_rx #(.CLK_DIV(CD), .SAMPLE_BITS(SB), .SLOT_BITS(SL), .STARTUP_FRAMES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master));

  logic          o_sck[2], o_ws[2], o_vld[2], o_lr[2];
  logic [SB-1:0] o_dat[2];
  assign o_sck[0] = if0.i2s_sck;  assign o_sck[1] = if2.i2s_sck;
  assign o_ws[0]  = if0.i2s_ws;   assign o_ws[1]  = if2.i2s_ws;
  assign o_vld[0] = if0.mic_valid; assign o_vld[1] = if2.mic_valid;
  assign o_lr[0]  = if0.finish_left_or_right; assign o_lr[1] = if2.finish_left_or_right;
  assign o_dat[0] = if0.mic_data; assign o_dat[1] = if2.mic_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mic BFM: tracks frame position from SCK falls and drives payload MSB-first at positions 1..SB, noise elsewhere.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !en) bfm_bit = 0;
      else if (bfm_prev && !if0.i2s_sck) bfm_bit = (bfm_bit + 1) % (2 * SL);
      bfm_prev = if0.i2s_sck;
      if ((bfm_bit % SL) >= 1 && (bfm_bit % SL) <= SB)
        sd = (bfm_bit >= SL) ? word_r[SB - (bfm_bit % SL)] : word_l[SB - (bfm_bit % SL)];
      else
        sd = 1'($urandom_range(0, 1));
    end
  end

  // Model: t counts clks since the enabling edge; all outputs follow from t by plain arithmetic.
  bit            m_run[2];
  int            m_t[2];
  logic          m_sck[2], m_ws[2], m_vld[2], m_lr[2];
  logic [SB-1:0] m_dat[2];

  task automatic step(input int i, input int sf);
    int t, k;
    if (!rst_n) begin
      m_run[i] = 0; m_t[i] = 0; m_dat[i] = '0; m_lr[i] = 1'b0;
    end else if (!m_run[i]) begin
      if (en) begin m_run[i] = 1; m_t[i] = 0; end
    end else if (!en) m_run[i] = 0;
    else m_t[i]++;
    m_vld[i] = 1'b0; m_sck[i] = 1'b0; m_ws[i] = 1'b0;
    if (m_run[i]) begin
      t = m_t[i];
      m_sck[i] = (t >= CD - 1) && (((t - CD + 1) / CD) % 2 == 0);
      m_ws[i]  = (((t + 1) / (2 * CD)) % (2 * SL)) >= SL;
      if (t >= CD && (t - CD) % (2 * CD) == 0) begin
        k = (t - CD) / (2 * CD);
        if (k % SL == SB && k / SL >= 2 * sf) begin
          m_vld[i] = 1'b1;
          m_lr[i]  = 1'((k / SL) % 2);
          m_dat[i] = m_lr[i] ? word_r : word_l;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, 0);
    step(1, 2);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("cycle dut%0d {sck,ws,vld,lr,dat}", i),
            {o_sck[i], o_ws[i], o_vld[i], o_lr[i], o_dat[i]},
            {m_sck[i], m_ws[i], m_vld[i], m_lr[i], m_dat[i]});
  end

  task automatic tick();
    @(posedge clk); #1; since_en++;
  endtask

  task automatic wait_valid(input int i, input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (o_vld[i]) ok = 1;
    end
    check($sformatf("valid timeout dut%0d", i), 64'(ok), 64'd1);
  endtask

  task automatic expect_sample(input int i, input int at, input logic [SB-1:0] dat, input logic lr);
    wait_valid(i, 1000);
    check($sformatf("valid cycle dut%0d", i), 64'(since_en), 64'(at));
    check($sformatf("mic_data dut%0d", i), 64'(o_dat[i]), 64'(dat));
    check($sformatf("lr flag dut%0d", i), 64'(o_lr[i]), 64'(lr));
  endtask

  task automatic wait_bfm_bit(input int target);
    bit ok;
    ok = 0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(posedge clk);
      if (bfm_bit == target) ok = 1;
    end
    check("bfm position timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with en high: everything static at zero.
    en = 1'b1; word_l = 24'h123456; word_r = 24'hABCDEF;
    repeat (4) begin
      @(posedge clk); #1;
      check("reset sck", 64'(if0.i2s_sck), 64'd0);
      check("reset outputs", {if2.i2s_sck, if2.i2s_ws, if2.mic_valid, if2.finish_left_or_right, if2.mic_data}, 64'd0);
    end
    @(negedge clk); rst_n = 1'b1; since_en = -1;
    tick();
    check("sck low on enabling clk", 64'(if0.i2s_sck), 64'd0);
    tick();
    check("first sck rise after 2 clks", 64'(if0.i2s_sck), 64'd1);

    // No warm-up: left then right, 128 clks apart, single-clk strobe.
    expect_sample(0, 98, 24'h123456, 1'b0);
    tick();
    check("valid strobe width", 64'(if0.mic_valid), 64'd0);
    expect_sample(0, 226, 24'hABCDEF, 1'b1);
    // Two warm-up frames: first valid is the left slot of frame 3.
    expect_sample(1, 610, 24'h123456, 1'b0);

    // Drop en at p=10 of the right slot.
    wait_bfm_bit(SL + 10);
    @(negedge clk); en = 1'b0;
    tick();
    check("en drop sck/ws/vld dut0", {if0.i2s_sck, if0.i2s_ws, if0.mic_valid}, 64'd0);
    check("en drop data held dut0", 64'(if0.mic_data), 64'h123456);
    check("en drop data held dut2", 64'(if2.mic_data), 64'h123456);
    repeat (5) tick();

    // Re-enable with a full-scale negative payload and noisy filler bits.
    word_l = 24'h800001; word_r = 24'h7FFFFF;
    @(negedge clk); en = 1'b1; since_en = -1;
    tick();
    check("re-enable ws left", {if0.i2s_ws, if2.i2s_ws}, 64'd0);
    expect_sample(0, 98, 24'h800001, 1'b0);
    expect_sample(0, 226, 24'h7FFFFF, 1'b1);
    expect_sample(1, 610, 24'h800001, 1'b0);

    // Asynchronous reset mid-word in RUN.
    wait_bfm_bit(12);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("async reset dut0", {if0.i2s_sck, if0.i2s_ws, if0.mic_valid, if0.finish_left_or_right, if0.mic_data}, 64'd0);
    check("async reset dut2", {if2.i2s_sck, if2.i2s_ws, if2.mic_valid, if2.finish_left_or_right, if2.mic_data}, 64'd0);
    word_l = 24'h123456; word_r = 24'hABCDEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; since_en = -1;
    expect_sample(0, 98, 24'h123456, 1'b0);
    expect_sample(0, 226, 24'hABCDEF, 1'b1);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
